// File: rtl/odometer_pkg.sv
// Shared types and helpers for the multi-channel odometer scan controller.
package odometer_pkg;

  localparam int MAX_CH = 16;
  localparam logic [31:0] OVF_ALL_ONES = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ARM,
    ST_COUNT,
    ST_OUT
  } state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } ch_pick_t;

  // Lowest set mask bit at index >= start; found=0 when no channel remains.
  function automatic ch_pick_t pick_ch(input logic [MAX_CH-1:0] mask,
                                       input logic [4:0]        start);
    ch_pick_t p;
    p = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= start)) begin
        p.found = 1'b1;
        p.idx   = 4'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/odometer_scan_ctrl_if.sv
// Result handshake bundle: controller drives channel/count/overflow, sink drives ready.
interface odometer_scan_ctrl_if #(
  parameter int N_CH    = 4,
  parameter int COUNT_W = 12
);
  localparam int CH_W = $clog2(N_CH);

  logic               res_valid;
  logic               res_ready;
  logic [CH_W-1:0]    res_ch;
  logic [COUNT_W-1:0] res_count;
  logic               res_ovf;

  modport master (
    output res_valid, res_ch, res_count, res_ovf,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_ch, res_count, res_ovf,
    output res_ready
  );
endinterface

// File: rtl/odometer_beat_sync.sv
// One channel of beat conditioning: 2-flop synchroniser and registered rising-edge pulse.
module odometer_beat_sync (
  input  logic clk,
  input  logic resetb,
  input  logic beat_in,
  output logic beat_pulse
);

  logic meta, sync, sync_d;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      meta       <= 1'b0;
      sync       <= 1'b0;
      sync_d     <= 1'b0;
      beat_pulse <= 1'b0;
    end else begin
      meta       <= beat_in;
      sync       <= meta;
      sync_d     <= sync;
      beat_pulse <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/odometer_scan_ctrl.sv
// Scans stress/reference oscillator pairs one at a time and reports the averaged
// beat period of each selected channel over a valid/ready result port.
module odometer_scan_ctrl
  import odometer_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int COUNT_W    = 12,
  parameter int AVG_LOG2   = 2,
  parameter int SETTLE_CYC = 16
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            load,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            ac_dc,
  input  logic            cont,
  input  logic            meas_trig,
  input  logic [N_CH-1:0] beat_in,
  output logic [N_CH-1:0] en_rosc,
  output logic [N_CH-1:0] meas_stress,
  output logic            ac_dc_latched,
  output logic            busy,
  odometer_scan_ctrl_if.master res
);

  localparam int CH_W   = $clog2(N_CH);
  localparam int ACC_W  = COUNT_W + AVG_LOG2;
  localparam int NBEATS = 1 << AVG_LOG2;
  localparam logic [COUNT_W-1:0]  CNT_MAX     = OVF_ALL_ONES[COUNT_W-1:0];
  localparam logic [COUNT_W-1:0]  SETTLE_LAST = COUNT_W'(SETTLE_CYC - 1);
  localparam logic [AVG_LOG2:0]   LAST_BEAT   = (AVG_LOG2 + 1)'(NBEATS - 1);

  state_t               state;
  logic [N_CH-1:0]      mask_q;
  logic                 cont_q;
  logic                 stop_pend;
  logic [CH_W-1:0]      ch_q;
  logic [COUNT_W-1:0]   cnt;
  logic [ACC_W-1:0]     acc;
  logic [AVG_LOG2:0]    beat_idx;

  logic [N_CH-1:0]      beat_pulse;
  logic                 sel_pulse;
  ch_pick_t             first_pick, next_pick, out_pick;
  logic [ACC_W-1:0]     acc_sum;

  odometer_beat_sync u_sync [N_CH-1:0] (
    .clk        (clk),
    .resetb     (resetb),
    .beat_in    (beat_in),
    .beat_pulse (beat_pulse)
  );

  function automatic logic [N_CH-1:0] onehot(input logic [3:0] idx);
    return N_CH'(1) << idx;
  endfunction

  assign sel_pulse  = beat_pulse[ch_q];
  assign first_pick = pick_ch(MAX_CH'(mask_q), 5'd0);
  assign next_pick  = pick_ch(MAX_CH'(mask_q), 5'(ch_q) + 5'd1);
  assign out_pick   = next_pick.found ? next_pick : first_pick;
  // Period is counter + 1: the counter restarts at 0 on the cycle after an edge.
  assign acc_sum    = acc + ACC_W'(cnt) + ACC_W'(1);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state         <= ST_IDLE;
      mask_q        <= '0;
      cont_q        <= 1'b0;
      stop_pend     <= 1'b0;
      ch_q          <= '0;
      cnt           <= '0;
      acc           <= '0;
      beat_idx      <= '0;
      en_rosc       <= '0;
      meas_stress   <= '0;
      ac_dc_latched <= 1'b0;
      busy          <= 1'b0;
      res.res_valid <= 1'b0;
      res.res_ch    <= '0;
      res.res_count <= '0;
      res.res_ovf   <= 1'b0;
    end else begin
      if (meas_trig && state != ST_IDLE) stop_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          stop_pend <= 1'b0;
          if (load) begin
            mask_q        <= ch_mask;
            ac_dc_latched <= ac_dc;
            cont_q        <= cont;
          end
          if (meas_trig && |mask_q) begin
            ch_q        <= CH_W'(first_pick.idx);
            en_rosc     <= onehot(first_pick.idx);
            meas_stress <= onehot(first_pick.idx);
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_ARM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_ARM: begin
          if (cnt == CNT_MAX) begin
            res.res_valid <= 1'b1;
            res.res_ch    <= ch_q;
            res.res_count <= CNT_MAX;
            res.res_ovf   <= 1'b1;
            state         <= ST_OUT;
          end else if (sel_pulse) begin
            cnt      <= '0;
            acc      <= '0;
            beat_idx <= '0;
            state    <= ST_COUNT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_COUNT: begin
          if (cnt == CNT_MAX) begin
            res.res_valid <= 1'b1;
            res.res_ch    <= ch_q;
            res.res_count <= CNT_MAX;
            res.res_ovf   <= 1'b1;
            state         <= ST_OUT;
          end else if (sel_pulse) begin
            acc <= acc_sum;
            cnt <= '0;
            if (beat_idx == LAST_BEAT) begin
              res.res_valid <= 1'b1;
              res.res_ch    <= ch_q;
              res.res_count <= COUNT_W'(acc_sum >> AVG_LOG2);
              res.res_ovf   <= 1'b0;
              state         <= ST_OUT;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_OUT: begin
          if (res.res_ready) begin
            res.res_valid <= 1'b0;
            // A trigger arriving on the accept cycle still counts as a stop.
            if (next_pick.found || (cont_q && !stop_pend && !meas_trig)) begin
              ch_q        <= CH_W'(out_pick.idx);
              en_rosc     <= onehot(out_pick.idx);
              meas_stress <= onehot(out_pick.idx);
              cnt         <= '0;
              state       <= ST_SETTLE;
            end else begin
              en_rosc     <= '0;
              meas_stress <= '0;
              busy        <= 1'b0;
              stop_pend   <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_odometer_scan_ctrl.sv
// Directed scenarios with a result scoreboard checked by an independent monitor.
module tb_odometer_scan_ctrl;

  localparam int N_CH    = 4;
  localparam int COUNT_W = 12;

  logic            clk = 1'b0;
  logic            resetb = 1'b0;
  logic            load = 1'b0;
  logic            ac_dc = 1'b0;
  logic            cont = 1'b0;
  logic            meas_trig = 1'b0;
  logic [N_CH-1:0] ch_mask = '0;
  wire  [N_CH-1:0] beat_in;
  logic [N_CH-1:0] en_rosc, meas_stress;
  logic            ac_dc_latched, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ch;
    int count;
    int ovf;
  } exp_t;
  exp_t exp_q[$];

  odometer_scan_ctrl_if #(.N_CH(N_CH), .COUNT_W(COUNT_W)) rif ();

  odometer_scan_ctrl #(.N_CH(N_CH), .COUNT_W(COUNT_W), .AVG_LOG2(2), .SETTLE_CYC(16)) dut (
    .clk           (clk),
    .resetb        (resetb),
    .load          (load),
    .ch_mask       (ch_mask),
    .ac_dc         (ac_dc),
    .cont          (cont),
    .meas_trig     (meas_trig),
    .beat_in       (beat_in),
    .en_rosc       (en_rosc),
    .meas_stress   (meas_stress),
    .ac_dc_latched (ac_dc_latched),
    .busy          (busy),
    .res           (rif)
  );

  always #5 clk = ~clk;

  // Per-channel beat source: queued periods first, else free-running gen_per (<2 = held low).
  for (genvar g = 0; g < N_CH; g++) begin : g_beat
    logic b = 1'b0;
    int   gen_per = 0;
    int   per_q[$];
    assign beat_in[g] = b;
    initial begin
      int p;
      forever begin
        if (per_q.size() > 0) p = per_q.pop_front();
        else p = gen_per;
        if (p < 2) begin
          b = 1'b0;
          @(posedge clk); #1;
        end else begin
          b = 1'b1;
          repeat (p / 2) @(posedge clk);
          #1;
          b = 1'b0;
          repeat (p - p / 2) @(posedge clk);
          #1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic exp_push(input int ch, input int count, input int ovf);
    exp_t e;
    e.ch = ch; e.count = count; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [N_CH-1:0] m, input logic ad, input logic c);
    ch_mask = m; ac_dc = ad; cont = c; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic trig();
    meas_trig = 1'b1;
    tick();
    meas_trig = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while (busy && n < max_cyc) begin tick(); n++; end
    chk(name, busy, 0);
  endtask

  task automatic wait_valid(input int max_cyc, input string name);
    int n = 0;
    while (!rif.res_valid && n < max_cyc) begin tick(); n++; end
    chk(name, rif.res_valid, 1);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold-stability while stalled.
  initial begin : monitor
    logic        held;
    logic [31:0] h_ch, h_cnt, h_ovf;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      chk("stress_onehot", 32'($onehot0(meas_stress)), 1);
      chk("en_eq_stress", 32'(en_rosc), 32'(meas_stress));
      if (rif.res_valid) begin
        if (held) begin
          chk("stall_ch", 32'(rif.res_ch), h_ch);
          chk("stall_count", 32'(rif.res_count), h_cnt);
          chk("stall_ovf", 32'(rif.res_ovf), h_ovf);
        end
        if (rif.res_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual ch=%0d count=%0h required none",
                     rif.res_ch, rif.res_count);
          end else begin
            e = exp_q.pop_front();
            chk("res_ch", 32'(rif.res_ch), e.ch);
            chk("res_count", 32'(rif.res_count), e.count);
            chk("res_ovf", 32'(rif.res_ovf), e.ovf);
          end
        end
        held  = !rif.res_ready;
        h_ch  = 32'(rif.res_ch);
        h_cnt = 32'(rif.res_count);
        h_ovf = 32'(rif.res_ovf);
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.res_ready = 1'b0;
    repeat (3) tick();
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_valid", rif.res_valid, 0);
    chk("rst_en", 32'(en_rosc), 0);
    chk("rst_stress", 32'(meas_stress), 0);
    chk("rst_acdc", ac_dc_latched, 0);
    chk("rst_count", 32'(rif.res_count), 0);
    chk("rst_ovf", rif.res_ovf, 0);
    resetb = 1'b1;
    tick();

    // Single channel, steady period 100
    do_load(4'b0001, 1'b1, 1'b0);
    chk("s1_acdc", ac_dc_latched, 1);
    g_beat[0].gen_per = 100;
    rif.res_ready = 1'b1;
    exp_push(0, 100, 0);
    trig();
    repeat (5) tick();
    chk("s1_busy", busy, 1);
    chk("s1_en", 32'(en_rosc), 32'h1);
    chk("s1_stress", 32'(meas_stress), 32'h1);
    wait_idle(2000, "s1_done");

    // Uneven periods 100,101,100,102 on ch2: 403>>2 = 100
    g_beat[0].gen_per = 0;
    do_load(4'b0100, 1'b0, 1'b0);
    chk("s2_acdc", ac_dc_latched, 0);
    exp_push(2, 100, 0);
    trig();
    repeat (40) tick();
    chk("s2_stress", 32'(meas_stress), 32'h4);
    g_beat[2].per_q.push_back(100);
    g_beat[2].per_q.push_back(101);
    g_beat[2].per_q.push_back(100);
    g_beat[2].per_q.push_back(102);
    g_beat[2].per_q.push_back(200);
    wait_idle(2000, "s2_done");
    repeat (250) tick();

    // Continuous scan of ch1/ch3 with stalled ready, LOAD ignored, stop mid-ch3
    g_beat[1].gen_per = 60;
    g_beat[3].gen_per = 80;
    rif.res_ready = 1'b0;
    do_load(4'b1010, 1'b0, 1'b1);
    exp_push(1, 60, 0);
    exp_push(3, 80, 0);
    exp_push(1, 60, 0);
    exp_push(3, 80, 0);
    trig();
    repeat (3) tick();
    do_load(4'b0001, 1'b1, 1'b0);
    chk("s3_load_ignored_acdc", ac_dc_latched, 0);
    for (int k = 0; k < 4; k++) begin
      wait_valid(3000, "s3_valid");
      repeat (20) tick();
      rif.res_ready = 1'b1;
      tick();
      rif.res_ready = 1'b0;
      if (k == 2) begin
        repeat (5) tick();
        trig();
      end
    end
    chk("s3_stop_idle", busy, 0);
    repeat (300) tick();
    chk("s3_stays_idle", busy, 0);

    // Stuck-low ch0 overflows, scan moves on to ch1
    g_beat[0].gen_per = 0;
    g_beat[1].gen_per = 50;
    rif.res_ready = 1'b1;
    do_load(4'b0011, 1'b0, 1'b0);
    exp_push(0, 'hFFF, 1);
    exp_push(1, 50, 0);
    trig();
    wait_idle(6000, "s4_done");

    // Zero mask ignores the trigger
    do_load(4'b0000, 1'b0, 1'b0);
    trig();
    repeat (5) tick();
    chk("s5_busy", busy, 0);
    chk("s5_en", 32'(en_rosc), 0);

    // Async reset mid-COUNT, then a clean measurement
    g_beat[0].gen_per = 100;
    do_load(4'b0001, 1'b1, 1'b0);
    trig();
    repeat (250) tick();
    chk("s6_busy_pre", busy, 1);
    #2;
    resetb = 1'b0;
    #1;
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_en", 32'(en_rosc), 0);
    chk("s6_rst_stress", 32'(meas_stress), 0);
    chk("s6_rst_valid", rif.res_valid, 0);
    chk("s6_rst_acdc", ac_dc_latched, 0);
    tick();
    resetb = 1'b1;
    tick();
    do_load(4'b0001, 1'b0, 1'b0);
    exp_push(0, 100, 0);
    trig();
    wait_idle(2000, "s6_done");

    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
